// File: rtl/btn_input_port.sv
// btn_input_port: memory-mapped button peripheral.
// Per-button two-flop synchroniser + debounce, press-event latch, CPU
// register window (STATE / EDGE / MASK / RAW) with registered read data.
// Optional feature macro: BTN_IRQ_EN (MASK register and level irq).

// One button lane: synchroniser, debounce counter, accepted level.
module btn_lane #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_25mhz,
  input  logic rst_n,
  input  logic btn,
  output logic raw,
  output logic stable,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic [CW-1:0] cnt;

  // accepted 0->1 change happens on the same edge stable updates
  assign rise = raw && !stable && (cnt == CNT_LAST);

  // sync chain plus debounce: count consecutive cycles away from stable
  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      raw    <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= btn;
      raw   <= sync1;
      if (raw == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= raw;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module btn_input_port #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int NUM_BTN         = 6
) (
  input  logic               clk_25mhz,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_i,
  input  logic [1:0]         addr,
  input  logic               re,
  input  logic               we,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               irq
);
  typedef enum logic [1:0] {
    REG_STATE = 2'd0,
    REG_EDGE  = 2'd1,
    REG_MASK  = 2'd2,
    REG_RAW   = 2'd3
  } reg_sel_e;

  logic [NUM_BTN-1:0] raw, stable, rise, edges, mask, clr;
  logic [31:0]        rd_val;

  btn_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane [NUM_BTN-1:0] (
    .clk_25mhz (clk_25mhz),
    .rst_n     (rst_n),
    .btn       (btn_i),
    .raw       (raw),
    .stable    (stable),
    .rise      (rise)
  );

  assign clr = (we && addr == REG_EDGE) ? wdata[NUM_BTN-1:0] : '0;

  // press latch: W1C clear, a same-cycle press wins over the clear
  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) edges <= '0;
    else        edges <= (edges & ~clr) | rise;
  end

`ifdef BTN_IRQ_EN
  // interrupt mask register
  always_ff @(posedge clk_25mhz) begin
    if (!rst_n)                        mask <= '0;
    else if (we && addr == REG_MASK)   mask <= wdata[NUM_BTN-1:0];
  end

  // level irq, registered from the current latch and mask
  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= |(edges & mask);
  end
`else
  assign mask = '0;
  assign irq  = 1'b0;
`endif

  // register read mux; sees pre-write values when re and we coincide
  always_comb begin
    rd_val = '0;
    case (reg_sel_e'(addr))
      REG_STATE: rd_val = 32'(stable);
      REG_EDGE:  rd_val = 32'(edges);
      REG_MASK:  rd_val = 32'(mask);
      REG_RAW:   rd_val = 32'(raw);
      default:   rd_val = '0;
    endcase
  end

  // registered read data, held while re is low
  always_ff @(posedge clk_25mhz) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= rd_val;
  end
endmodule

// File: tb/tb_btn_input_port.sv
// Self-checking bench for btn_input_port (DEBOUNCE_CYCLES=4, NUM_BTN=6).
// Reference model: a button level is accepted once the last DC synchronised
// samples all disagree with the currently accepted level.
module tb_btn_input_port;
  localparam int DC = 4;
  localparam int NB = 6;

  logic          clk_25mhz = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn_i = '0;
  logic [1:0]    addr = '0;
  logic          re = 1'b0;
  logic          we = 1'b0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          irq;

  int n_cmp = 0;
  int n_bad = 0;

  always #20 clk_25mhz = ~clk_25mhz;

  btn_input_port #(.DEBOUNCE_CYCLES(DC), .NUM_BTN(NB)) dut (
    .clk_25mhz (clk_25mhz),
    .rst_n     (rst_n),
    .btn_i     (btn_i),
    .addr      (addr),
    .re        (re),
    .we        (we),
    .wdata     (wdata),
    .rdata     (rdata),
    .irq       (irq)
  );

  // ---------------- reference model ----------------
  logic [NB-1:0]         m_s1, m_s2, m_stable, m_edge, m_mask;
  logic [DC-1:0][NB-1:0] m_win, m_view;
  logic [NB-1:0]         m_flip;
  logic [31:0]           m_rdata;
  logic                  m_irq;

  function automatic logic [NB-1:0] settled(input logic [DC-1:0][NB-1:0] w,
                                            input logic [NB-1:0] st);
    logic [NB-1:0] r;
    for (int i = 0; i < NB; i++) begin
      r[i] = 1'b1;
      for (int j = 0; j < DC; j++) if (w[j][i] == st[i]) r[i] = 1'b0;
    end
    return r;
  endfunction

  assign m_view = {m_win[DC-2:0], m_s2};
  assign m_flip = settled(m_view, m_stable);

  always @(posedge clk_25mhz) begin
    if (!rst_n) begin
      m_s1 <= '0; m_s2 <= '0; m_stable <= '0; m_edge <= '0; m_mask <= '0;
      m_win <= '0; m_rdata <= '0; m_irq <= 1'b0;
    end else begin
      m_s1     <= btn_i;
      m_s2     <= m_s1;
      m_win    <= m_view;
      m_stable <= m_stable ^ m_flip;
      m_edge   <= (m_edge & ~((we && addr == 2'd1) ? wdata[NB-1:0] : '0))
                  | (m_flip & ~m_stable);
`ifdef BTN_IRQ_EN
      if (we && addr == 2'd2) m_mask <= wdata[NB-1:0];
      m_irq <= |(m_edge & m_mask);
`endif
      if (re) begin
        case (addr)
          2'd0: m_rdata <= 32'(m_stable);
          2'd1: m_rdata <= 32'(m_edge);
          2'd2: m_rdata <= 32'(m_mask);
          default: m_rdata <= 32'(m_s2);
        endcase
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_25mhz); #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] got, output logic [31:0] mdl);
    addr = a; re = 1'b1;
    tick();
    re = 1'b0;
    got = rdata;
    mdl = m_rdata;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] got, mdl, exp;
    rst_n = 1'b0; btn_i = 6'h3F;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
      n_cmp++;
      if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    end
    rst_n = 1'b1;
    for (int j = 0; j <= 6; j++) begin
      rd(2'd0, got, mdl);
      exp = (j == 6) ? 32'h3F : 32'h0;
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL reset_state[%0d] got=%h exp=%h", j, got, exp); end
      n_cmp++;
      if (got !== mdl) begin n_bad++; $display("FAIL reset_state_model got=%h exp=%h", got, mdl); end
    end
    rd(2'd1, got, mdl);
    n_cmp++;
    if (got !== 32'h3F) begin n_bad++; $display("FAIL reset_edge got=%h exp=3f", got); end
    btn_i = '0; settle(8); wr(2'd1, 32'h3F);
    rd(2'd1, got, mdl);
    n_cmp++;
    if (got !== 32'h0) begin n_bad++; $display("FAIL reset_edge_clr got=%h exp=0", got); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] got, mdl, exp;
    btn_i = 6'h01; settle(4);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int j = 0; j <= 6; j++) begin
      rd(2'd0, got, mdl);
      exp = (j == 6) ? 32'h01 : 32'h0;
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL midrst_state[%0d] got=%h exp=%h", j, got, exp); end
    end
    rd(2'd1, got, mdl);
    n_cmp++;
    if (got !== 32'h01) begin n_bad++; $display("FAIL midrst_edge got=%h exp=01", got); end
    btn_i = '0; settle(8); wr(2'd1, 32'h3F);
  endtask

  task automatic test_clean_press();
    logic [31:0] got, mdl, exp;
    btn_i = 6'h01;
    tick();
    rd(2'd3, got, mdl);
    n_cmp++;
    if (got !== 32'h0) begin n_bad++; $display("FAIL press_raw_early got=%h exp=0", got); end
    rd(2'd3, got, mdl);
    n_cmp++;
    if (got !== 32'h01) begin n_bad++; $display("FAIL press_raw got=%h exp=01", got); end
    for (int j = 0; j < 4; j++) begin
      rd(2'd0, got, mdl);
      exp = (j == 3) ? 32'h01 : 32'h0;
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL press_state[%0d] got=%h exp=%h", j, got, exp); end
    end
    rd(2'd1, got, mdl);
    n_cmp++;
    if (got !== 32'h01) begin n_bad++; $display("FAIL press_edge got=%h exp=01", got); end
    btn_i = '0; settle(7);
    rd(2'd0, got, mdl);
    n_cmp++;
    if (got !== 32'h0) begin n_bad++; $display("FAIL release_state got=%h exp=0", got); end
    rd(2'd1, got, mdl);
    n_cmp++;
    if (got !== 32'h01) begin n_bad++; $display("FAIL release_edge got=%h exp=01", got); end
    wr(2'd1, 32'h3F);
  endtask

  task automatic test_bounce();
    logic [31:0] got, mdl;
    for (int p = 0; p < 3; p++) begin
      btn_i = 6'h04; settle(3);
      btn_i = 6'h00; settle(1);
    end
    settle(6);
    rd(2'd0, got, mdl);
    n_cmp++;
    if (got !== 32'h0) begin n_bad++; $display("FAIL bounce_state got=%h exp=0", got); end
    rd(2'd1, got, mdl);
    n_cmp++;
    if (got !== 32'h0) begin n_bad++; $display("FAIL bounce_edge got=%h exp=0", got); end
    btn_i = 6'h04; settle(7);
    rd(2'd0, got, mdl);
    n_cmp++;
    if (got !== 32'h04) begin n_bad++; $display("FAIL bounce_hold_state got=%h exp=04", got); end
    n_cmp++;
    if (got !== mdl) begin n_bad++; $display("FAIL bounce_model got=%h exp=%h", got, mdl); end
    btn_i = '0; settle(7); wr(2'd1, 32'h3F);
  endtask

  task automatic test_w1c_race();
    logic [31:0] got, mdl;
    btn_i = 6'h03; settle(7);
    btn_i = 6'h00; settle(7);
    rd(2'd1, got, mdl);
    n_cmp++;
    if (got !== 32'h03) begin n_bad++; $display("FAIL w1c_pre got=%h exp=03", got); end
    wr(2'd1, 32'h01);
    rd(2'd1, got, mdl);
    n_cmp++;
    if (got !== 32'h02) begin n_bad++; $display("FAIL w1c_one got=%h exp=02", got); end
    btn_i = 6'h10; settle(5);
    wr(2'd1, 32'h3F);
    rd(2'd1, got, mdl);
    n_cmp++;
    if (got !== 32'h10) begin n_bad++; $display("FAIL w1c_race got=%h exp=10", got); end
    n_cmp++;
    if (got !== mdl) begin n_bad++; $display("FAIL w1c_model got=%h exp=%h", got, mdl); end
    btn_i = '0; settle(7); wr(2'd1, 32'h3F);
  endtask

  task automatic test_irq();
    logic [31:0] got, mdl;
`ifdef BTN_IRQ_EN
    wr(2'd2, 32'h01);
    rd(2'd2, got, mdl);
    n_cmp++;
    if (got !== 32'h01) begin n_bad++; $display("FAIL irq_mask got=%h exp=01", got); end
    btn_i = 6'h02; settle(7);
    rd(2'd1, got, mdl);
    n_cmp++;
    if (got !== 32'h02) begin n_bad++; $display("FAIL irq_edge got=%h exp=02", got); end
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_masked got=%b exp=0", irq); end
    btn_i = 6'h03;
    for (int j = 0; j < 6; j++) begin
      tick();
      n_cmp++;
      if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_early[%0d] got=%b exp=0", j, irq); end
    end
    tick();
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_assert got=%b exp=1", irq); end
    wr(2'd1, 32'h01);
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_hold got=%b exp=1", irq); end
    tick();
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear got=%b exp=0", irq); end
    btn_i = '0; settle(7); wr(2'd1, 32'h3F); wr(2'd2, 32'h0);
`else
    wr(2'd2, 32'h3F);
    rd(2'd2, got, mdl);
    n_cmp++;
    if (got !== 32'h0) begin n_bad++; $display("FAIL nomask_read got=%h exp=0", got); end
    btn_i = 6'h01;
    for (int j = 0; j < 8; j++) begin
      tick();
      n_cmp++;
      if (irq !== 1'b0) begin n_bad++; $display("FAIL noirq[%0d] got=%b exp=0", j, irq); end
    end
    btn_i = '0; settle(7); wr(2'd1, 32'h3F);
`endif
  endtask

  task automatic test_sweep();
    logic [31:0] got, mdl;
    for (int v = 0; v < 64; v++) begin
      btn_i = NB'(v);
      for (int j = 0; j < 10; j++) begin
        if (j == 6) begin
          rd(2'd0, got, mdl);
          n_cmp++;
          if (got !== 32'(v)) begin n_bad++; $display("FAIL sweep_state[%0d] got=%h exp=%h", v, got, v); end
        end else begin
          tick();
        end
      end
    end
    btn_i = '0; settle(10);
    rd(2'd0, got, mdl);
    n_cmp++;
    if (got !== 32'h0) begin n_bad++; $display("FAIL sweep_final_state got=%h exp=0", got); end
    rd(2'd1, got, mdl);
    n_cmp++;
    if (got !== 32'h3F) begin n_bad++; $display("FAIL sweep_final_edge got=%h exp=3f", got); end
    wr(2'd1, 32'h3F);
  endtask

  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 800; c++) begin
      if (hold == 0) begin
        btn_i = NB'($urandom);
        hold  = int'($urandom_range(1, 8));
      end
      hold--;
      re    = 1'($urandom);
      we    = ($urandom_range(0, 3) == 0);
      addr  = 2'($urandom);
      wdata = $urandom;
      tick();
      n_cmp++;
      if (rdata !== m_rdata) begin n_bad++; $display("FAIL rand_rdata[%0d] got=%h exp=%h", c, rdata, m_rdata); end
      n_cmp++;
      if (irq !== m_irq) begin n_bad++; $display("FAIL rand_irq[%0d] got=%b exp=%b", c, irq, m_irq); end
    end
    re = 1'b0; we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mid_reset();
    test_clean_press();
    test_bounce();
    test_w1c_race();
    test_irq();
    test_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
